gate_conditioner: RTL and testbench
===================================

Name: gate_conditioner

Overview:
- Front-end stage that produces the clean gate consumed by the samplers and the ramp (top-level `i_gate`).
- Synchronises an asynchronous external gate and rejects pulses shorter than a programmable minimum width.
- Emits one-cycle edge strobes and reports the width of each accepted gate and a running gate count.
- Runs on `sys_clock`; sits between the board pin and the sampler/FSM.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `i_gate_async` (minimum 2).
- FILTER_SIZE, 4, width of the minimum-width setting and the qualification counter.
- COUNT_SIZE, 16, width of the gate-width and gate-count registers.

Ports:
- i_clock  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  reset; asynchronous, active-high.
- i_gate_async  in  1  raw external gate, asynchronous to `i_clock`.
- i_enable  in  1  1 = conditioner active; 0 = force idle.
- i_min_width  in  FILTER_SIZE  minimum stable cycles (M) for a level change; 0 is treated as 1.
- o_gate  out  1  filtered gate.
- o_gate_rise  out  1  one-cycle pulse in the first cycle `o_gate`=1.
- o_gate_fall  out  1  one-cycle pulse in the first cycle `o_gate`=0 after a high period.
- o_glitch  out  1  one-cycle pulse when a too-short high pulse is rejected.
- o_gate_width  out  COUNT_SIZE  high time, in cycles, of the last completed gate.
- o_width_valid  out  1  one-cycle pulse, coincident with `o_gate_fall`, when `o_gate_width` updates.
- o_gate_count  out  COUNT_SIZE  number of accepted gates (rising edges).

Behaviour:
- Reset (async assert): synchroniser flops = 0, state = IDLE, all outputs and internal counters = 0. Deassertion is synchronous to `i_clock` by construction upstream; no further sync is done here.
- s = output of the last synchroniser stage. An `i_gate_async` edge appears on s after SYNC_STAGES edges.
- M is latched into a qualification register on entry to QUAL_HIGH/QUAL_LOW. Changes to `i_min_width` during qualification take effect on the next qualification.
- FSM states: IDLE, QUAL_HIGH, ACTIVE, QUAL_LOW. `o_gate`=1 in ACTIVE and QUAL_LOW only.
- IDLE:
  - s=1 and M=1: go to ACTIVE.
  - s=1 and M>1: go to QUAL_HIGH, qual_cnt=1.
- QUAL_HIGH:
  - s=0: go to IDLE and pulse `o_glitch`.
  - s=1: qual_cnt+1; when qual_cnt+1 == M, go to ACTIVE.
- ACTIVE:
  - s=0 and M=1: go to IDLE.
  - s=0 and M>1: go to QUAL_LOW, qual_cnt=1.
- QUAL_LOW:
  - s=1: return to ACTIVE; a low glitch is silently absorbed and no pulse is produced.
  - s=0: qual_cnt+1; when it reaches M, go to IDLE.
- Latency: `o_gate` changes on the M-th consecutive edge at which s is sampled at the new level. Total latency from a pin edge is SYNC_STAGES+M cycles.
- On entering ACTIVE from IDLE or QUAL_HIGH:
  - `o_gate_rise`=1 for one cycle.
  - `o_gate_count` increments, wrapping all-ones → 0.
  - width_cnt loads 1.
- While `o_gate`=1, width_cnt increments each cycle and saturates at all-ones.
- On `o_gate` going 1→0: `o_gate_fall`=1 and `o_width_valid`=1 for one cycle, and `o_gate_width` ← width_cnt, i.e. the exact number of cycles `o_gate` was high.
- `i_enable`=0:
  - Next state is IDLE regardless of s; qual_cnt clears.
  - If `o_gate` was 1, fall/width_valid pulse normally with the truncated width.
  - The synchroniser keeps running.
  - On re-enable with s=1, normal qualification from IDLE applies.
- Reset mid-gate: outputs clear immediately; no fall or width pulse is generated.
- Edge strobes and `o_glitch` never assert in the same cycle.

Optional Feature:
- Macro GATE_COND_GLITCH_CNT_EN.
- Defined: adds output port `o_glitch_count` [COUNT_SIZE], reset to 0. It increments once per `o_glitch` pulse, saturates at all-ones, and clears when `i_enable`=0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, M=4, `i_gate_async` high for 20 cycles → `o_gate` rises 2+4=6 edges after the pin edge. `o_gate_rise` is a single pulse, `o_gate_count`=1, `o_gate_width`=20, and `o_width_valid` pulses with `o_gate_fall`.
- M=4, 3-cycle high pulse → `o_gate` stays 0, one `o_glitch` pulse, `o_gate_count` unchanged; glitch count=1 when the macro is defined.
- M=4, gate high with a 2-cycle low dip mid-gate → a single continuous `o_gate` high, one rise, one fall, width = total high span including the dip.
- M=0 and M=1 with a 5-cycle pulse → `o_gate` high for exactly 5 cycles, width=5, latency SYNC_STAGES+1.
- `i_enable` dropped 10 cycles into an active gate → `o_gate` falls the next cycle, `o_gate_width`=10 (cycles `o_gate` was high before the drop); no rise while disabled even though the pin stays high.
- COUNT_SIZE=4, 17 accepted gates → `o_gate_count` wraps to 1. A gate held 40 cycles reports `o_gate_width`=15 (saturated). Async reset mid-gate → all outputs 0 with no fall pulse.

Source files
------------

// File: rtl/gate_conditioner.sv
// Gate conditioner: synchronises an external gate, rejects short pulses, and reports edges, width and count.
// Define GATE_COND_GLITCH_CNT_EN to add the o_glitch_count output (rejected high pulses).
module gate_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_SIZE = 4,
  parameter int COUNT_SIZE  = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_gate_async,
  input  logic                   i_enable,
  input  logic [FILTER_SIZE-1:0] i_min_width,
  output logic                   o_gate,
  output logic                   o_gate_rise,
  output logic                   o_gate_fall,
  output logic                   o_glitch,
  output logic [COUNT_SIZE-1:0]  o_gate_width,
  output logic                   o_width_valid,
  output logic [COUNT_SIZE-1:0]  o_gate_count
`ifdef GATE_COND_GLITCH_CNT_EN
  ,
  output logic [COUNT_SIZE-1:0]  o_glitch_count
`endif
);

  localparam logic [FILTER_SIZE-1:0] F_ONE = FILTER_SIZE'(1);
  localparam logic [COUNT_SIZE-1:0]  C_ONE = COUNT_SIZE'(1);
  localparam logic [COUNT_SIZE-1:0]  C_MAX = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    QUAL_HIGH = 2'd1,
    ACTIVE    = 2'd2,
    QUAL_LOW  = 2'd3
  } state_t;

  function automatic logic [COUNT_SIZE-1:0] sat_inc(input logic [COUNT_SIZE-1:0] v);
    return (v == C_MAX) ? v : v + C_ONE;
  endfunction

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic [FILTER_SIZE-1:0] qual_cnt, qual_cnt_next, qual_inc;
  logic [FILTER_SIZE-1:0] qual_m, qual_m_next;
  logic                   m_is_one;
  logic                   glitch_next;
  logic                   gate_next;
  logic [COUNT_SIZE-1:0]  width_cnt;

  // Stage p0: synchroniser chain, s is the last flop
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) sync_p0 <= '0;
    else         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], i_gate_async};
  end

  assign s        = sync_p0[SYNC_STAGES-1];
  assign m_is_one = (i_min_width <= F_ONE);
  assign o_gate   = (state == ACTIVE) || (state == QUAL_LOW);

  always_comb begin
    state_next    = state;
    qual_cnt_next = qual_cnt;
    qual_m_next   = qual_m;
    glitch_next   = 1'b0;
    qual_inc      = qual_cnt + F_ONE;
    if (!i_enable) begin
      state_next    = IDLE;
      qual_cnt_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (s) begin
            if (m_is_one) begin
              state_next = ACTIVE;
            end else begin
              state_next    = QUAL_HIGH;
              qual_cnt_next = F_ONE;
              qual_m_next   = i_min_width;
            end
          end
        end
        QUAL_HIGH: begin
          if (!s) begin
            state_next    = IDLE;
            qual_cnt_next = '0;
            glitch_next   = 1'b1;
          end else if (qual_inc == qual_m) begin
            state_next    = ACTIVE;
            qual_cnt_next = '0;
          end else begin
            qual_cnt_next = qual_inc;
          end
        end
        ACTIVE: begin
          if (!s) begin
            if (m_is_one) begin
              state_next = IDLE;
            end else begin
              state_next    = QUAL_LOW;
              qual_cnt_next = F_ONE;
              qual_m_next   = i_min_width;
            end
          end
        end
        QUAL_LOW: begin
          // A low dip shorter than M returns to ACTIVE with no strobe
          if (s) begin
            state_next    = ACTIVE;
            qual_cnt_next = '0;
          end else if (qual_inc == qual_m) begin
            state_next    = IDLE;
            qual_cnt_next = '0;
          end else begin
            qual_cnt_next = qual_inc;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    gate_next = (state_next == ACTIVE) || (state_next == QUAL_LOW);
  end

  // Stage p1: state, strobes and width/count bookkeeping
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      qual_cnt      <= '0;
      qual_m        <= '0;
      o_gate_rise   <= 1'b0;
      o_gate_fall   <= 1'b0;
      o_width_valid <= 1'b0;
      o_glitch      <= 1'b0;
      width_cnt     <= '0;
      o_gate_width  <= '0;
      o_gate_count  <= '0;
    end else begin
      state         <= state_next;
      qual_cnt      <= qual_cnt_next;
      qual_m        <= qual_m_next;
      o_gate_rise   <= gate_next & ~o_gate;
      o_gate_fall   <= ~gate_next & o_gate;
      o_width_valid <= ~gate_next & o_gate;
      o_glitch      <= glitch_next;
      if (gate_next && !o_gate) begin
        width_cnt    <= C_ONE;
        o_gate_count <= o_gate_count + C_ONE;
      end else if (gate_next) begin
        width_cnt <= sat_inc(width_cnt);
      end
      if (!gate_next && o_gate) o_gate_width <= width_cnt;
    end
  end

`ifdef GATE_COND_GLITCH_CNT_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)          o_glitch_count <= '0;
    else if (!i_enable)   o_glitch_count <= '0;
    else if (glitch_next) o_glitch_count <= sat_inc(o_glitch_count);
  end
`endif

endmodule

// File: tb/tb_gate_conditioner.sv
// Scoreboard bench for gate_conditioner: two instances (16-bit and 4-bit counters) share stimulus
// and are compared cycle by cycle against a run-length reference model.
module tb_gate_conditioner;
  localparam int SS = 2;
  localparam int FS = 4;

  typedef struct {
    logic gate;
    logic rise;
    logic fall;
    logic glitch;
    logic wv;
    int   width;
    int   count;
    int   gcnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          pin = 1'b0;
  logic          en  = 1'b1;
  logic [FS-1:0] mw  = 4'd4;

  logic        a_gate, a_rise, a_fall, a_glitch, a_wv;
  logic [15:0] a_width, a_count, a_gcnt;
  logic        b_gate, b_rise, b_fall, b_glitch, b_wv;
  logic [3:0]  b_width, b_count, b_gcnt;

  gate_conditioner #(.SYNC_STAGES(SS), .FILTER_SIZE(FS), .COUNT_SIZE(16)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_gate_async(pin), .i_enable(en), .i_min_width(mw),
    .o_gate(a_gate), .o_gate_rise(a_rise), .o_gate_fall(a_fall), .o_glitch(a_glitch),
    .o_gate_width(a_width), .o_width_valid(a_wv), .o_gate_count(a_count)
`ifdef GATE_COND_GLITCH_CNT_EN
    , .o_glitch_count(a_gcnt)
`endif
  );

  gate_conditioner #(.SYNC_STAGES(SS), .FILTER_SIZE(FS), .COUNT_SIZE(4)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_gate_async(pin), .i_enable(en), .i_min_width(mw),
    .o_gate(b_gate), .o_gate_rise(b_rise), .o_gate_fall(b_fall), .o_glitch(b_glitch),
    .o_gate_width(b_width), .o_width_valid(b_wv), .o_gate_count(b_count)
`ifdef GATE_COND_GLITCH_CNT_EN
    , .o_glitch_count(b_gcnt)
`endif
  );

`ifndef GATE_COND_GLITCH_CNT_EN
  assign a_gcnt = '0;
  assign b_gcnt = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Reference model: pin delay line, current gate level and length of the opposing run
  logic sq[$];
  logic g[2];
  int   run[2], rm[2], wc[2], gw[2], gc[2], glc[2];
  int   maxv[2] = '{65535, 15};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    sq.delete();
    for (int k = 0; k < SS; k++) sq.push_back(1'b0);
    for (int d = 0; d < 2; d++) begin
      g[d] = 1'b0; run[d] = 0; rm[d] = 1; wc[d] = 0; gw[d] = 0; gc[d] = 0; glc[d] = 0;
    end
  endtask

  task automatic model_edge();
    exp_t e;
    logic s, was_h, rise, fall, gl;
    int   m;
    if (rst) begin
      model_reset();
      e = '{default: 0};
      qa.push_back(e);
      qb.push_back(e);
      return;
    end
    sq.push_back(pin);
    s = sq.pop_front();
    m = (mw == 0) ? 1 : int'(mw);
    for (int d = 0; d < 2; d++) begin
      was_h = g[d];
      gl    = 1'b0;
      if (!en) begin
        g[d] = 1'b0; run[d] = 0; glc[d] = 0;
      end else if (s != g[d]) begin
        if (run[d] == 0) rm[d] = m;
        run[d]++;
        if (run[d] >= rm[d]) begin g[d] = s; run[d] = 0; end
      end else begin
        if (!g[d] && run[d] > 0) gl = 1'b1;
        run[d] = 0;
      end
      rise = g[d] && !was_h;
      fall = !g[d] && was_h;
      if (rise) begin
        wc[d] = 1;
        gc[d] = (gc[d] == maxv[d]) ? 0 : gc[d] + 1;
      end else if (g[d] && wc[d] < maxv[d]) begin
        wc[d]++;
      end
      if (fall) gw[d] = wc[d];
      if (gl && glc[d] < maxv[d]) glc[d]++;
      e.gate = g[d]; e.rise = rise; e.fall = fall; e.glitch = gl; e.wv = fall;
      e.width = gw[d]; e.count = gc[d]; e.gcnt = glc[d];
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  task automatic apply(input logic p, input logic e, input logic [FS-1:0] m, input logic r_in);
    pin = p; en = e; mw = m; rst = r_in;
    model_edge();
  endtask

  task automatic drive(input logic p, input logic e, input logic [FS-1:0] m, input logic r_in);
    @(negedge clk);
    apply(p, e, m, r_in);
  endtask

  // Pin high for hi cycles then low for lo; lat = first cycle index where o_gate is seen high
  task automatic pulse(input int hi, input int lo, input logic [FS-1:0] m, output int lat);
    lat = -1;
    for (int i = 0; i < hi + lo; i++) begin
      drive(i < hi, 1'b1, m, 1'b0);
      if (lat < 0 && a_gate) lat = i;
    end
  endtask

  task automatic check_rec(input string t, input exp_t e, input logic gt, input logic ri,
                           input logic fa, input logic gl, input logic wv, input logic [31:0] w,
                           input logic [31:0] c, input logic [31:0] gcv);
    chk({t, "_gate"},   32'(gt), 32'(e.gate));
    chk({t, "_rise"},   32'(ri), 32'(e.rise));
    chk({t, "_fall"},   32'(fa), 32'(e.fall));
    chk({t, "_glitch"}, 32'(gl), 32'(e.glitch));
    chk({t, "_wvalid"}, 32'(wv), 32'(e.wv));
    chk({t, "_width"},  w, e.width);
    chk({t, "_count"},  c, e.count);
`ifdef GATE_COND_GLITCH_CNT_EN
    chk({t, "_glitch_count"}, gcv, e.gcnt);
`endif
  endtask

  // Monitor: one expected record per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check_rec("a", e, a_gate, a_rise, a_fall, a_glitch, a_wv, 32'(a_width), 32'(a_count), 32'(a_gcnt));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check_rec("b", e, b_gate, b_rise, b_fall, b_glitch, b_wv, 32'(b_width), 32'(b_count), 32'(b_gcnt));
      end
    end
  end

  initial begin
    int lat, hc, hi, lo;
    logic [FS-1:0] m;
    model_reset();
    repeat (3) drive(1'b0, 1'b1, 4'd4, 1'b1);

    // 20-cycle gate, M=4
    pulse(20, 12, 4'd4, lat);
    chk("lat_m4", lat, SS + 4);
    chk("width20", 32'(a_width), 20);
    chk("count1", 32'(a_count), 1);
    chk("width20_sat4", 32'(b_width), 15);

    // 3-cycle pulse rejected
    pulse(3, 12, 4'd4, lat);
    chk("glitch_no_gate", lat, -1);
    chk("glitch_count_unch", 32'(a_count), 1);
`ifdef GATE_COND_GLITCH_CNT_EN
    chk("glitch_cnt1", 32'(a_gcnt), 1);
`endif

    // 2-cycle low dip absorbed
    for (int i = 0; i < 30; i++) drive((i < 8) || (i >= 10 && i < 18), 1'b1, 4'd4, 1'b0);
    chk("dip_width", 32'(a_width), 18);
    chk("dip_count", 32'(a_count), 2);

    // M=0 and M=1 pass a 5-cycle pulse unchanged
    pulse(5, 10, 4'd0, lat);
    chk("lat_m0", lat, SS + 1);
    chk("width_m0", 32'(a_width), 5);
    pulse(5, 10, 4'd1, lat);
    chk("lat_m1", lat, SS + 1);
    chk("width_m1", 32'(a_width), 5);
    chk("count4", 32'(a_count), 4);

    // Enable dropped after 10 high cycles, pin kept high
    hc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (a_gate) hc++;
      apply(1'b1, hc < 10, 4'd4, 1'b0);
      if (hc >= 10) break;
    end
    repeat (8) drive(1'b1, 1'b0, 4'd4, 1'b0);
    chk("en_width", 32'(a_width), 10);
    chk("en_no_rise", 32'(a_count), 5);
    repeat (12) drive(1'b1, 1'b1, 4'd4, 1'b0);
    repeat (12) drive(1'b0, 1'b1, 4'd4, 1'b0);
    chk("reenable_count", 32'(a_count), 6);

    // Randomised pulses, widths, thresholds and enable drops
    for (int k = 0; k < 60; k++) begin
      hi = $urandom_range(1, 10);
      lo = $urandom_range(1, 10);
      m  = 4'($urandom_range(0, 6));
      for (int i = 0; i < hi + lo; i++) drive(i < hi, $urandom_range(0, 24) != 0, m, 1'b0);
    end
    repeat (15) drive(1'b0, 1'b1, 4'd4, 1'b0);

    // Count wrap and width saturation on the 4-bit instance
    repeat (2) drive(1'b0, 1'b1, 4'd1, 1'b1);
    for (int k = 0; k < 17; k++) pulse(2, 4, 4'd1, lat);
    chk("wrap_b", 32'(b_count), 1);
    chk("wrap_a", 32'(a_count), 17);
    pulse(40, 8, 4'd1, lat);
    chk("lat_40", lat, SS + 1);
    chk("sat_b", 32'(b_width), 15);
    chk("width40_a", 32'(a_width), 40);

    // Asynchronous reset in the middle of a gate
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 1'b1, 4'd4, (i >= 15) && (i < 18));
      if (i == 15) begin
        #1;
        chk("rst_gate", 32'(a_gate), 0);
        chk("rst_count", 32'(a_count), 0);
        chk("rst_width", 32'(a_width), 0);
        chk("rst_fall", 32'(a_fall), 0);
        chk("rst_b_count", 32'(b_count), 0);
      end
    end
    repeat (15) drive(1'b0, 1'b1, 4'd4, 1'b0);

    @(posedge clk);
    #2;
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
